adxl355_i2c_sequencer: RTL and testbench



---
 rtl/adxl355_pkg.sv | 50 +++++
 rtl/adxl355_i2c_sequencer_if.sv | 22 ++
 rtl/adxl355_frame_unpack.sv | 27 ++
 rtl/adxl355_i2c_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_adxl355_i2c_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adxl355_pkg.sv
// Shared ADXL355 register map, I2C controller field positions, error codes
// and the sequencer state/frame types.
package adxl355_pkg;

    localparam logic [7:0] REG_TEMP2     = 8'h06;
    localparam logic [7:0] REG_RANGE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;

    typedef enum logic [1:0] {
        OP_CPU_1  = 2'd0,
        OP_CPU_11 = 2'd1,
        OP_HW_11  = 2'd2
    } op_mode_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RW      = 1;
    localparam int CTRL_OP_LSB  = 2;
    localparam int CTRL_CLK_LSB = 4;

    localparam int STAT_READY  = 0;
    localparam int STAT_FINISH = 1;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_REQ,
        S_CFG_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_ASSEMBLE,
        S_ERR
    } seq_state_e;

    typedef struct packed {
        logic [11:0] temp;
        logic [31:0] acc_x;
        logic [31:0] acc_y;
        logic [31:0] acc_z;
    } frame_t;

    function automatic logic [31:0] sext20(input logic [19:0] v);
        return {{12{v[19]}}, v};
    endfunction

endpackage

// File: rtl/adxl355_i2c_sequencer_if.sv
// Sequencer <-> I2C controller bus: control word, addressing, status and the
// eleven read-back bytes (rd_data[0] is byte 1).
interface adxl355_i2c_sequencer_if;

    logic [31:0]      ctrl;
    logic [6:0]       dev_addr;
    logic [7:0]       reg_addr;
    logic [7:0]       w_data;
    logic [31:0]      status;
    logic [10:0][7:0] rd_data;

    modport master (
        output ctrl, dev_addr, reg_addr, w_data,
        input  status, rd_data
    );

    modport slave (
        input  ctrl, dev_addr, reg_addr, w_data,
        output status, rd_data
    );

endinterface

// File: rtl/adxl355_frame_unpack.sv
// Splits the 11-byte TEMP2..ZDATA1 burst into temperature and sign-extended
// 20-bit XYZ fields. Purely combinational; the parent registers it.
module adxl355_frame_unpack
    import adxl355_pkg::*;
(
    input  logic [10:0][7:0] i_bytes,
    output frame_t           o_frame
);

    logic [19:0] w_x;
    logic [19:0] w_y;
    logic [19:0] w_z;
    logic        w_unused_bits;

    assign w_x = {i_bytes[2], i_bytes[3], i_bytes[4][7:4]};
    assign w_y = {i_bytes[5], i_bytes[6], i_bytes[7][7:4]};
    assign w_z = {i_bytes[8], i_bytes[9], i_bytes[10][7:4]};

    assign o_frame.temp  = {i_bytes[0][3:0], i_bytes[1]};
    assign o_frame.acc_x = sext20(w_x);
    assign o_frame.acc_y = sext20(w_y);
    assign o_frame.acc_z = sext20(w_z);

    // Reserved nibbles of the data registers carry no measurement
    assign w_unused_bits = ^{i_bytes[0][7:4], i_bytes[4][3:0], i_bytes[7][3:0], i_bytes[10][3:0]};

endmodule

// File: rtl/adxl355_i2c_sequencer.sv
// Drives the I2C controller: writes RANGE and POWER_CTL after reset, then one
// 11-byte TEMP2 burst read per trigger, unpacked into temperature and XYZ.
module adxl355_i2c_sequencer
    import adxl355_pkg::*;
#(
    parameter logic [6:0]  P_DEV_ADDR  = 7'h1D,
    parameter logic [7:0]  P_START_REG = REG_TEMP2,
    parameter logic [7:0]  P_RANGE_VAL = 8'h01,
    parameter logic [2:0]  P_CLK_RATE  = 3'd6,
    parameter logic [19:0] P_TIMEOUT   = 20'd400000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_trig,
    adxl355_i2c_sequencer_if.master io_i2c,
    output logic [11:0]             o_temp,
    output logic [31:0]             o_acc_x,
    output logic [31:0]             o_acc_y,
    output logic [31:0]             o_acc_z,
    output logic                    o_valid,
    output logic                    o_cfg_done,
    output logic [1:0]              o_err,
    output logic                    o_overrun
);

    seq_state_e  r_state;
    seq_state_e  w_next;
    logic        r_cfg_idx;
    logic        r_cfg_done;
    logic        r_rdy;
    logic        r_fin;
    logic        r_fin_d;
    logic        r_seen_rdy;
    logic        r_fin_seen;
    logic        r_pending;
    logic        r_overrun;
    logic        r_valid;
    logic [19:0] r_tmo_cnt;
    err_e        r_err;
    logic [31:0] r_ctrl;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_w_data;
    frame_t      r_frame;
    frame_t      w_frame;

    logic        w_fin_rise;
    logic        w_tmo_hit;
    logic        w_is_req;
    logic        w_in_txn;
    logic        w_req_entry;
    logic        w_nack;
    logic        w_tmo;
    logic        w_cfg_adv;
    logic        w_cfg_fin;
    logic        w_en;
    logic        w_rw;
    op_mode_e    w_op;
    logic [7:0]  w_reg;
    logic [7:0]  w_wd;
    logic        w_unused_status;

    adxl355_frame_unpack u_unpack (
        .i_bytes (io_i2c.rd_data),
        .o_frame (w_frame)
    );

    assign w_fin_rise  = r_fin & ~r_fin_d;
    assign w_tmo_hit   = (r_tmo_cnt >= P_TIMEOUT);
    assign w_is_req    = (r_state == S_CFG_REQ) || (r_state == S_RD_REQ);
    assign w_in_txn    = w_is_req || (r_state == S_CFG_WAIT) || (r_state == S_RD_WAIT);
    assign w_req_entry = ((w_next == S_CFG_REQ) || (w_next == S_RD_REQ)) && (w_next != r_state);

    // A REQ only advances on ready=0 after it has seen ready=1, so a status
    // still low from reset or from the previous transfer is not taken as acceptance.
    always_comb begin
        w_next    = r_state;
        w_nack    = 1'b0;
        w_tmo     = 1'b0;
        w_cfg_adv = 1'b0;
        w_cfg_fin = 1'b0;
        w_en      = 1'b0;
        w_rw      = 1'b0;
        w_op      = OP_CPU_1;
        w_reg     = 8'h00;
        w_wd      = 8'h00;
        unique case (r_state)
            S_IDLE: begin
                if (i_trig || r_pending) w_next = S_RD_REQ;
            end
            S_CFG_REQ, S_CFG_WAIT: begin
                w_en  = (r_state == S_CFG_REQ);
                w_reg = r_cfg_idx ? REG_POWER_CTL : REG_RANGE;
                w_wd  = r_cfg_idx ? 8'h00 : P_RANGE_VAL;
                if (w_tmo_hit) begin
                    w_tmo  = 1'b1;
                    w_next = S_ERR;
                end else if (r_state == S_CFG_REQ) begin
                    if (r_seen_rdy && !r_rdy) w_next = S_CFG_WAIT;
                end else if (r_rdy) begin
                    if (r_fin_seen || w_fin_rise) begin
                        if (r_cfg_idx) begin
                            w_cfg_fin = 1'b1;
                            w_next    = S_IDLE;
                        end else begin
                            w_cfg_adv = 1'b1;
                            w_next    = S_CFG_REQ;
                        end
                    end else begin
                        w_nack = 1'b1;
                        w_next = S_ERR;
                    end
                end
            end
            S_RD_REQ, S_RD_WAIT, S_ASSEMBLE: begin
                w_en  = (r_state == S_RD_REQ);
                w_rw  = 1'b1;
                w_op  = OP_CPU_11;
                w_reg = P_START_REG;
                if (r_state == S_ASSEMBLE) begin
                    w_next = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo  = 1'b1;
                    w_next = S_ERR;
                end else if (r_state == S_RD_REQ) begin
                    if (r_seen_rdy && !r_rdy) w_next = S_RD_WAIT;
                end else if (w_fin_rise) begin
                    w_next = S_ASSEMBLE;
                end else if (r_rdy) begin
                    w_nack = 1'b1;
                    w_next = S_ERR;
                end
            end
            S_ERR: begin
                w_next = r_cfg_done ? S_IDLE : S_CFG_REQ;
            end
            default: w_next = S_CFG_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdy   <= 1'b0;
            r_fin   <= 1'b0;
            r_fin_d <= 1'b0;
        end else begin
            r_rdy   <= io_i2c.status[STAT_READY];
            r_fin   <= io_i2c.status[STAT_FINISH];
            r_fin_d <= r_fin;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_CFG_REQ;
            r_cfg_idx  <= 1'b0;
            r_cfg_done <= 1'b0;
            r_seen_rdy <= 1'b0;
            r_fin_seen <= 1'b0;
            r_tmo_cnt  <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= ERR_NONE;
        end else begin
            r_state <= w_next;
            if (w_cfg_adv) r_cfg_idx <= 1'b1;
            if (w_cfg_fin) r_cfg_done <= 1'b1;
            if (w_req_entry) begin
                r_tmo_cnt  <= '0;
                r_seen_rdy <= 1'b0;
                r_fin_seen <= 1'b0;
            end else if (w_in_txn) begin
                r_tmo_cnt <= r_tmo_cnt + 20'd1;
                if (w_is_req && r_rdy) r_seen_rdy <= 1'b1;
                if (w_fin_rise) r_fin_seen <= 1'b1;
            end
            // IDLE consumes both a fresh trigger and a pending one as a single read
            r_overrun <= i_trig && (r_state != S_IDLE) && r_pending;
            if (w_tmo || (r_state == S_IDLE)) r_pending <= 1'b0;
            else if (i_trig) r_pending <= 1'b1;
            if (w_tmo) r_err <= ERR_TIMEOUT;
            else if (w_nack) r_err <= ERR_NACK;
            else if (r_state == S_ASSEMBLE) r_err <= ERR_NONE;
            r_valid <= (r_state == S_ASSEMBLE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ctrl     <= {25'd0, P_CLK_RATE, 4'd0};
            r_reg_addr <= '0;
            r_w_data   <= '0;
            r_frame    <= '0;
        end else begin
            r_ctrl     <= {25'd0, P_CLK_RATE, w_op, w_rw, w_en};
            r_reg_addr <= w_reg;
            r_w_data   <= w_wd;
            if (r_state == S_ASSEMBLE) r_frame <= w_frame;
        end
    end

    assign io_i2c.ctrl     = r_ctrl;
    assign io_i2c.dev_addr = P_DEV_ADDR;
    assign io_i2c.reg_addr = r_reg_addr;
    assign io_i2c.w_data   = r_w_data;

    assign o_temp     = r_frame.temp;
    assign o_acc_x    = r_frame.acc_x;
    assign o_acc_y    = r_frame.acc_y;
    assign o_acc_z    = r_frame.acc_z;
    assign o_valid    = r_valid;
    assign o_cfg_done = r_cfg_done;
    assign o_err      = r_err;
    assign o_overrun  = r_overrun;

    assign w_unused_status = ^io_i2c.status[31:2];

endmodule

// File: tb/tb_adxl355_i2c_sequencer.sv
// Sequencer bench: behavioural I2C controller model plus a field-level
// reference model for the unpacked burst-read results.
module tb_adxl355_i2c_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic [11:0] temp;
    logic [31:0] acc_x, acc_y, acc_z;
    logic        valid, cfg_done, overrun;
    logic [1:0]  err;

    int n_chk = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_ovr = 0;
    int n_rd = 0;
    int lat = 12;
    bit nack_req = 1'b0;
    bit hang_req = 1'b0;
    int frame[11];
    logic [18:0] wlog[$];
    logic [10:0] last_rd = '0;

    logic m_rdy, m_fin, m_busy;
    int   m_cnt;

    adxl355_i2c_sequencer_if bus();

    adxl355_i2c_sequencer #(.P_TIMEOUT(20'd1000)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_trig     (trig),
        .io_i2c     (bus),
        .o_temp     (temp),
        .o_acc_x    (acc_x),
        .o_acc_y    (acc_y),
        .o_acc_z    (acc_z),
        .o_valid    (valid),
        .o_cfg_done (cfg_done),
        .o_err      (err),
        .o_overrun  (overrun)
    );

    always #10 clk = ~clk;

    assign bus.status = {30'd0, m_fin, m_rdy};

    // Controller model: accepts enable while ready, busy for lat cycles, then
    // raises finish together with ready (or ready alone on a NACK).
    always @(posedge clk) begin
        if (!rst_n) begin
            m_rdy  <= 1'b1;
            m_fin  <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (bus.ctrl[0] && m_rdy) begin
                if (bus.ctrl[1]) begin
                    n_rd    <= n_rd + 1;
                    last_rd <= {bus.ctrl[3:1], bus.reg_addr};
                end else begin
                    wlog.push_back({bus.ctrl[3:1], bus.reg_addr, bus.w_data});
                end
                m_rdy  <= 1'b0;
                m_fin  <= 1'b0;
                m_busy <= 1'b1;
                m_cnt  <= lat;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else if (!hang_req) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b1;
            if (!nack_req) begin
                m_fin <= 1'b1;
                for (int i = 0; i < 11; i++) bus.rd_data[i] <= 8'(frame[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
        if (overrun) n_ovr <= n_ovr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int ref_temp();
        return (frame[0] % 16) * 256 + frame[1];
    endfunction

    function automatic int ref_acc(input int hi, input int mid, input int lo);
        int v;
        v = hi * 4096 + mid * 16 + lo / 16;
        if (v >= 524288) v = v - 1048576;
        return v;
    endfunction

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int v0);
        int k = 0;
        while (n_valid == v0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid_seen"}, 32'(n_valid != v0), 32'd1);
    endtask

    task automatic wait_cfg(input string tag);
        int k = 0;
        while (!cfg_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_cfg_done"}, 32'(cfg_done), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, bus.ctrl, 32'h0000_0060);
        chk({tag, "_dev_addr"}, 32'(bus.dev_addr), 32'h1D);
        chk({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'h0);
        chk({tag, "_w_data"}, 32'(bus.w_data), 32'h0);
        chk({tag, "_temp"}, 32'(temp), 32'h0);
        chk({tag, "_acc_x"}, acc_x, 32'h0);
        chk({tag, "_acc_z"}, acc_z, 32'h0);
        chk({tag, "_flags"}, {27'd0, valid, cfg_done, err, overrun}, 32'h0);
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_temp"}, 32'(temp), 32'(ref_temp()));
        chk({tag, "_acc_x"}, acc_x, 32'(ref_acc(frame[2], frame[3], frame[4])));
        chk({tag, "_acc_y"}, acc_y, 32'(ref_acc(frame[5], frame[6], frame[7])));
        chk({tag, "_acc_z"}, acc_z, 32'(ref_acc(frame[8], frame[9], frame[10])));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, r0, o0, w0, k;
        frame = '{8'h08, 8'h7F, 8'h12, 8'h34, 8'h50, 8'hFF, 8'hFF, 8'hF0, 8'h80, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");

        // configuration after reset release
        rst_n = 1'b1;
        wait_cfg("cfg");
        chk("cfg_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            chk("cfg_wr0", 32'(wlog[0]), {13'd0, 3'b000, 8'h2C, 8'h01});
            chk("cfg_wr1", 32'(wlog[1]), {13'd0, 3'b000, 8'h2D, 8'h00});
        end
        chk("cfg_err", 32'(err), 32'd0);

        // directed frame
        v0 = n_valid;
        pulse_trig();
        wait_valid("dir", v0);
        repeat (20) @(negedge clk);
        chk("dir_temp", 32'(temp), 32'h87F);
        chk("dir_acc_x", acc_x, 32'h0001_2345);
        chk("dir_acc_y", acc_y, 32'hFFFF_FFFF);
        chk("dir_acc_z", acc_z, 32'hFFF8_0000);
        chk("dir_one_valid", 32'(n_valid - v0), 32'd1);
        chk("dir_rd_req", 32'(last_rd), {21'd0, 3'b011, 8'h06});

        // random frames against the reference model
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 11; i++) frame[i] = int'($urandom_range(0, 255));
            lat = int'($urandom_range(4, 30));
            v0 = n_valid;
            pulse_trig();
            wait_valid("rnd", v0);
            repeat (5) @(negedge clk);
            chk_fields("rnd");
        end

        // NACK on a read, then recovery
        nack_req = 1'b1;
        v0 = n_valid;
        pulse_trig();
        k = 0;
        while (err == 2'd0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("nack_err", 32'(err), 32'd1);
        repeat (10) @(negedge clk);
        chk("nack_no_valid", 32'(n_valid - v0), 32'd0);
        nack_req = 1'b0;
        for (int i = 0; i < 11; i++) frame[i] = int'($urandom_range(0, 255));
        v0 = n_valid;
        pulse_trig();
        wait_valid("recov", v0);
        repeat (3) @(negedge clk);
        chk("recov_err_clr", 32'(err), 32'd0);
        chk_fields("recov");

        // three triggers, one read in flight
        lat = 20;
        v0 = n_valid; r0 = n_rd; o0 = n_ovr;
        pulse_trig();
        repeat (4) @(negedge clk);
        pulse_trig();
        repeat (4) @(negedge clk);
        pulse_trig();
        repeat (300) @(negedge clk);
        chk("ovr_reads", 32'(n_rd - r0), 32'd2);
        chk("ovr_pulses", 32'(n_ovr - o0), 32'd1);
        chk("ovr_valids", 32'(n_valid - v0), 32'd2);

        // controller hangs: timeout, pending trigger dropped
        lat = 12;
        hang_req = 1'b1;
        v0 = n_valid; r0 = n_rd;
        pulse_trig();
        repeat (50) @(negedge clk);
        pulse_trig();
        repeat (400) @(negedge clk);
        chk("tmo_early_err", 32'(err), 32'd0);
        k = 0;
        while (err == 2'd0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_err", 32'(err), 32'd2);
        repeat (3) @(negedge clk);
        chk("tmo_en_low", 32'(bus.ctrl[0]), 32'd0);
        hang_req = 1'b0;
        repeat (100) @(negedge clk);
        chk("tmo_no_retry", 32'(n_rd - r0), 32'd1);
        chk("tmo_no_valid", 32'(n_valid - v0), 32'd0);
        chk("tmo_err_sticky", 32'(err), 32'd2);

        // reset in the middle of a read
        lat = 40;
        w0 = wlog.size();
        pulse_trig();
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("mid_rst");
        lat = 12;
        rst_n = 1'b1;
        wait_cfg("recfg");
        chk("recfg_nwrites", 32'(wlog.size() - w0), 32'd2);
        if (wlog.size() >= w0 + 2) begin
            chk("recfg_wr0", 32'(wlog[w0]), {13'd0, 3'b000, 8'h2C, 8'h01});
            chk("recfg_wr1", 32'(wlog[w0 + 1]), {13'd0, 3'b000, 8'h2D, 8'h00});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
